// File: rtl/lsu_pkg.sv
// Shared types and op-decode helpers for the load/store unit.
package lsu_pkg;

  localparam int MEMOP_WIDTH = 4;

  typedef enum logic [MEMOP_WIDTH-1:0] {
    MEM_NONE,
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LD,
    MEM_LBU,
    MEM_LHU,
    MEM_LWU,
    MEM_SB,
    MEM_SH,
    MEM_SW,
    MEM_SD
  } memop_t;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  function automatic logic is_load(input memop_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LD, MEM_LBU, MEM_LHU, MEM_LWU};
  endfunction

  function automatic logic is_store(input memop_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SD};
  endfunction

  function automatic logic [2:0] op_size(input memop_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: op_size = SIZE_B;
      MEM_LH, MEM_LHU, MEM_SH: op_size = SIZE_H;
      MEM_LW, MEM_LWU, MEM_SW: op_size = SIZE_W;
      default:                 op_size = SIZE_D;
    endcase
  endfunction

  function automatic logic op_signed(input memop_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NBYTE = XLEN / 8
) (
  input  memop_t            op,
  input  logic [2:0]        offset,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   st_data,
  output logic [NBYTE-1:0]  st_strobe,
  output logic [XLEN-1:0]   ld_data
);

  logic [5:0]         shamt;
  logic [2:0]         size;
  logic [3:0]         nbytes;
  logic [NBYTE:0]     byte_mask;
  logic [2*NBYTE-1:0] strobe_wide;
  logic [XLEN-1:0]    shifted;
  logic               sgn;

  assign shamt = {offset, 3'b000};
  assign size  = op_size(op);
  assign sgn   = op_signed(op);

  // Lanes and strobes past the 8-byte beat are simply dropped.
  always_comb begin
    st_data     = wdata << shamt;
    nbytes      = 4'd1 << size;
    byte_mask   = ((NBYTE+1)'(1) << nbytes) - (NBYTE+1)'(1);
    strobe_wide = {{NBYTE{1'b0}}, byte_mask[NBYTE-1:0]} << offset;
    st_strobe   = is_store(op) ? strobe_wide[NBYTE-1:0] : '0;
  end

  always_comb begin
    shifted = rdata >> shamt;
    case (size)
      SIZE_B:  ld_data = sgn ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
      SIZE_H:  ld_data = sgn ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
      SIZE_W:  ld_data = sgn ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one bus transaction per memory op, result to writeback.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NBYTE = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  memop_t            mem_op,
  output logic [XLEN-1:0]   lsu_out,
  output logic              lsu_finish,
  output logic              lsu_busy,
  output logic              dreq_valid,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [NBYTE-1:0]  dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  lsu_state_t        state, state_d;
  memop_t            op_q;
  logic [2:0]        off_q;
  memop_t            align_op;
  logic [2:0]        align_off;
  logic [XLEN-1:0]   st_data;
  logic [NBYTE-1:0]  st_strobe;
  logic [XLEN-1:0]   ld_data;
  logic              is_mem_in;
  logic              trap;

  assign is_mem_in = is_load(mem_op) | is_store(mem_op);

`ifdef MISALIGN_TRAP_EN
  logic [2:0] amask;
  logic       mis_q;
  assign amask    = 3'((4'd1 << op_size(mem_op)) - 4'd1);
  assign trap     = is_mem_in & (|(addr[2:0] & amask));
  assign misalign = mis_q;
`else
  assign trap = 1'b0;
`endif

  // The single aligner serves the incoming op in IDLE, the latched op afterwards.
  assign align_op  = (state == ST_IDLE) ? mem_op    : op_q;
  assign align_off = (state == ST_IDLE) ? addr[2:0] : off_q;

  lsu_align #(.XLEN(XLEN), .NBYTE(NBYTE)) u_align (
    .op        (align_op),
    .offset    (align_off),
    .wdata     (wdata),
    .rdata     (dresp_data),
    .st_data   (st_data),
    .st_strobe (st_strobe),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    lsu_finish = 1'b0;
    lsu_busy   = (state != ST_IDLE);
    dreq_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lsu_valid) state_d = (!is_mem_in || trap) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        dreq_valid = 1'b1;
        // A data_ok without addr_ok implies the address was taken as well.
        if (dresp_data_ok)      state_d = ST_DONE;
        else if (dresp_addr_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dresp_data_ok) state_d = ST_DONE;
      end
      ST_DONE: begin
        lsu_finish = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= MEM_NONE;
      off_q       <= '0;
      lsu_out     <= '0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (lsu_valid) begin
            op_q  <= mem_op;
            off_q <= addr[2:0];
`ifdef MISALIGN_TRAP_EN
            mis_q <= trap;
`endif
            if (!is_mem_in || trap) begin
              lsu_out <= addr;
            end else begin
              dreq_addr   <= {addr[XLEN-1:3], 3'b000};
              dreq_size   <= op_size(mem_op);
              dreq_strobe <= st_strobe;
              dreq_data   <= st_data;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          if (dresp_data_ok) lsu_out <= is_load(op_q) ? ld_data : '0;
        end
        ST_DONE: begin
`ifdef MISALIGN_TRAP_EN
          mis_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
